// File: rtl/mux_logic_unit.sv
// Streaming bit-sliced 2:1-mux logic unit: per-beat bitwise ops or a folded
// reduction over a multi-beat stream, results queued in a small output FIFO.
module mux_logic_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_beats
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_NAND   = 3'd2,
    OP_NOR    = 3'd3,
    OP_XOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_PASS_B = 3'd7
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_e;

  // Each result bit is a 2:1 mux steered by the x operand bit.
  function automatic logic [WIDTH-1:0] mux_fn(input op_e op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      case (op)
        OP_AND:    r[i] = x[i] ? y[i]  : 1'b0;
        OP_OR:     r[i] = x[i] ? 1'b1  : y[i];
        OP_NAND:   r[i] = x[i] ? ~y[i] : 1'b1;
        OP_NOR:    r[i] = x[i] ? 1'b0  : ~y[i];
        OP_XOR:    r[i] = x[i] ? ~y[i] : y[i];
        OP_XNOR:   r[i] = x[i] ? y[i]  : ~y[i];
        OP_PASS_A: r[i] = x[i];
        default:   r[i] = y[i];
      endcase
    end
    return r;
  endfunction

  // Fold state
  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  op_e              fold_op_q, fold_op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // FIFO state
  logic [WIDTH-1:0] y_mem_q     [DEPTH];
  logic             zero_mem_q  [DEPTH];
  logic [CNT_W-1:0] beats_mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             in_ready_q;

  logic             accept;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_y;
  logic [CNT_W-1:0] push_beats;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cnt_sat;

  assign accept  = in_valid && in_ready_q;
  assign pop     = (count_q != '0) && out_ready;
  assign cnt_sat = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    fold_op_d  = fold_op_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_y     = '0;
    push_beats = '0;
    res        = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          res = mux_fn(op_e'(in_op), in_a, in_b);
          if (!in_mode || in_last) begin
            push       = 1'b1;
            push_y     = res;
            push_beats = CNT_W'(1);
          end
          if (in_mode) begin
            fold_op_d = op_e'(in_op);
            cnt_d     = CNT_W'(1);
            if (!in_last) begin
              acc_d   = res;
              state_d = S_ACC;
            end
          end
        end
      end
      S_ACC: begin
        if (accept) begin
          res   = mux_fn(fold_op_q, acc_q, in_b);
          cnt_d = cnt_sat;
          if (in_last) begin
            push       = 1'b1;
            push_y     = res;
            push_beats = cnt_sat;
            state_d    = S_IDLE;
          end else begin
            acc_d = res;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      fold_op_q <= OP_AND;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      fold_op_q <= fold_op_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // in_ready is registered from the next occupancy, so a pop out of a full
  // FIFO only re-opens the input on the following cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        y_mem_q[i]     <= '0;
        zero_mem_q[i]  <= 1'b0;
        beats_mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (push) begin
        y_mem_q[wr_ptr_q]     <= push_y;
        zero_mem_q[wr_ptr_q]  <= (push_y == '0);
        beats_mem_q[wr_ptr_q] <= push_beats;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q    <= count_d;
      in_ready_q <= (count_d != FIFO_FULL);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != '0);
  assign out_y     = y_mem_q[rd_ptr_q];
  assign out_zero  = zero_mem_q[rd_ptr_q];
  assign out_beats = beats_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_mux_logic_unit.sv
// Directed and scoreboarded checks for mux_logic_unit (WIDTH=8, DEPTH=2, CNT_W=8).
module tb_mux_logic_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       in_mode;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       out_zero;
  logic [7:0] out_beats;

  int unsigned n_tests;
  int unsigned n_fail;

  mux_logic_unit #(.WIDTH(8), .DEPTH(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero  (out_zero),
    .out_beats (out_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat and return 1 time unit after the edge that accepted it.
  task automatic beat(input logic [2:0] op, input logic mode, input logic last,
                      input logic [7:0] a, input logic [7:0] b);
    int unsigned guard;
    in_op = op; in_mode = mode; in_last = last; in_a = a; in_b = b;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) check("beat_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return a;
      default: return b;
    endcase
  endfunction

  logic [7:0] exp_t1 [8];
  logic [7:0] q [$];

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_mode = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    exp_t1[0] = 8'h30; exp_t1[1] = 8'hFC; exp_t1[2] = 8'hCF; exp_t1[3] = 8'h03;
    exp_t1[4] = 8'hCC; exp_t1[5] = 8'h33; exp_t1[6] = 8'hF0; exp_t1[7] = 8'h3C;

    // Reset state
    step(); step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_y", 32'(out_y), 32'h0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    check("rst_out_beats", 32'(out_beats), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1. Bitwise ops
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat(3'(i), 1'b0, 1'b0, 8'hF0, 8'h3C);
      check($sformatf("t1_valid_op%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("t1_y_op%0d", i), 32'(out_y), 32'(exp_t1[i]));
      check($sformatf("t1_beats_op%0d", i), 32'(out_beats), 32'd1);
      check($sformatf("t1_zero_op%0d", i), 32'(out_zero), 32'd0);
    end
    beat(3'd4, 1'b0, 1'b0, 8'hFF, 8'hFF);
    check("t1_xor_ff_y", 32'(out_y), 32'h00);
    check("t1_xor_ff_zero", 32'(out_zero), 32'd1);
    step();
    check("t1_drained", 32'(out_valid), 32'd0);

    // 2. Three-beat XOR fold
    beat(3'd4, 1'b1, 1'b0, 8'h01, 8'h02);
    check("t2_mid1_valid", 32'(out_valid), 32'd0);
    beat(3'd0, 1'b1, 1'b0, 8'hEE, 8'h04);
    check("t2_mid2_valid", 32'(out_valid), 32'd0);
    beat(3'd0, 1'b0, 1'b1, 8'hEE, 8'h08);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_y", 32'(out_y), 32'h0F);
    check("t2_beats", 32'(out_beats), 32'd3);
    step();
    check("t2_drained", 32'(out_valid), 32'd0);

    // 3. Single-beat fold, then a bitwise beat proves the FSM is idle
    beat(3'd0, 1'b1, 1'b1, 8'hAA, 8'h0F);
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_y", 32'(out_y), 32'h0A);
    check("t3_beats", 32'(out_beats), 32'd1);
    beat(3'd7, 1'b0, 1'b0, 8'h00, 8'h55);
    check("t3_idle_y", 32'(out_y), 32'h55);
    check("t3_idle_beats", 32'(out_beats), 32'd1);
    step();
    check("t3_drained", 32'(out_valid), 32'd0);

    // 4. Backpressure
    out_ready = 1'b0;
    beat(3'd4, 1'b0, 1'b0, 8'h01, 8'h00);
    beat(3'd4, 1'b0, 1'b0, 8'h02, 8'h00);
    check("t4_full_in_ready", 32'(in_ready), 32'd0);
    in_op = 3'd4; in_mode = 1'b0; in_last = 1'b0; in_a = 8'h03; in_b = 8'h00;
    in_valid = 1'b1;
    step(); step();
    check("t4_held_in_ready", 32'(in_ready), 32'd0);
    check("t4_head0", 32'(out_y), 32'h01);
    out_ready = 1'b1;
    step();
    check("t4_ready_rise", 32'(in_ready), 32'd1);
    check("t4_head1", 32'(out_y), 32'h02);
    step();
    in_valid = 1'b0;
    check("t4_head2", 32'(out_y), 32'h03);
    check("t4_head2_valid", 32'(out_valid), 32'd1);
    step();
    check("t4_drained", 32'(out_valid), 32'd0);

    // 5. Random bitwise stream against a queue model
    begin
      int unsigned sent, cycles;
      logic hold;
      sent = 0; cycles = 0; hold = 1'b0;
      q.delete();
      while ((sent < 20 || q.size() != 0) && cycles < 1000) begin
        if (cycles < 4) out_ready = 1'b0;
        else if (cycles == 4) out_ready = 1'b1;
        else out_ready = 1'($urandom_range(0, 1));
        if (!hold) begin
          in_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
          in_op = 3'($urandom_range(0, 7));
          in_a = 8'($urandom);
          in_b = 8'($urandom);
          in_mode = 1'b0; in_last = 1'b0;
        end
        check("t5_in_ready", 32'(in_ready), 32'(q.size() != 2));
        check("t5_out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (out_valid && out_ready && q.size() != 0) begin
          check("t5_y", 32'(out_y), 32'(q[0]));
          check("t5_zero", 32'(out_zero), 32'(q[0] == 8'h00));
          check("t5_beats", 32'(out_beats), 32'd1);
          void'(q.pop_front());
        end
        if (in_valid && in_ready) begin
          q.push_back(model(in_op, in_a, in_b));
          sent++;
          hold = 1'b0;
        end else begin
          hold = in_valid;
        end
        step();
        cycles++;
      end
      in_valid = 1'b0;
      if (cycles >= 1000) check("t5_timeout", 32'(cycles), 32'd0);
    end

    // 6. Reset mid-fold
    out_ready = 1'b1;
    step();
    beat(3'd1, 1'b1, 1'b0, 8'h11, 8'h22);
    beat(3'd1, 1'b1, 1'b0, 8'h00, 8'h44);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("t6_after_rst_valid", 32'(out_valid), 32'd0);
    beat(3'd0, 1'b0, 1'b0, 8'h0F, 8'hFF);
    check("t6_valid", 32'(out_valid), 32'd1);
    check("t6_y", 32'(out_y), 32'h0F);
    check("t6_beats", 32'(out_beats), 32'd1);
    step();
    check("t6_single_output", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_logic_unit.md
Name: mux_logic_unit

Overview:
- WIDTH-bit, bit-sliced 2:1-mux logic unit. The operation is selected per beat: AND, OR, NAND, NOR, XOR, XNOR, PASS_A or PASS_B.
- Adds valid/ready handshaking, a fold (reduction-over-stream) mode and a DEPTH-entry output FIFO.
- Sits between a stream producer and consumer as the registered, streaming generation of the team's single-bit mux gates.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
DEPTH, 2, output FIFO entries (power of 2, >=2)
CNT_W, 8, width of the per-result beat counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  unit can accept a beat
in_a  input  WIDTH  operand A (used on bitwise beats and the first fold beat)
in_b  input  WIDTH  operand B
in_op  input  3  0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 PASS_A, 7 PASS_B
in_mode  input  1  0 bitwise, 1 fold
in_last  input  1  last beat of a fold (ignored in bitwise mode)
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_y  output  WIDTH  result at FIFO head
out_zero  output  1  out_y == 0
out_beats  output  CNT_W  input beats that produced this result

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, rst_n). While rst_n=0 at a rising edge:
  - FIFO is emptied; out_valid=0, out_y=0, out_zero=0 (registered, not derived from out_y), out_beats=0.
  - Fold state goes to IDLE; accumulator=0; beat counter=0.
  - in_ready=0 during reset, then 1 from the first cycle after release.
- Per-bit function, mux form f(x,y):
  - AND: x ? y : 0
  - OR: x ? 1 : y
  - NAND: x ? ~y : 1
  - NOR: x ? 0 : ~y
  - XOR: x ? ~y : y
  - XNOR: x ? y : ~y
  - PASS_A: x
  - PASS_B: y
- Accept: a beat is accepted when in_valid && in_ready. in_ready = !fifo_full, registered from the FIFO count.
- Bitwise mode, with fold state IDLE and in_mode=0:
  - Pushes f(in_a, in_b) with out_beats=1.
  - A beat accepted at edge N gives out_valid=1 in cycle N+1 if the FIFO was empty.
- Fold FSM, states IDLE and ACC:
  - IDLE with an accepted beat, in_mode=1:
    - Computes r = f(in_a, in_b) and latches in_op as fold_op; count=1.
    - If in_last=1: push r with out_beats=1, stay IDLE. Otherwise acc<=r and go to ACC.
  - ACC with an accepted beat:
    - Computes r = f(acc, in_b) using fold_op. in_a, in_op and in_mode are ignored. count saturates at 2^CNT_W-1.
    - If in_last=1: push r with out_beats=count+1 (saturated) and go to IDLE. Otherwise acc<=r.
  - Non-last fold beats never push but still require in_ready=1.
- FIFO: standard circular buffer with read/write pointers wrapping modulo DEPTH.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle: occupancy unchanged, order preserved.
  - When full, in_ready=0, so a pop frees a slot and in_ready rises in the next cycle (no same-cycle pass-through).
  - out_y, out_zero and out_beats always reflect the head entry.
  - out_y and out_beats hold the last popped value when empty (don't-care). out_zero stays registered.
- out_zero is stored per entry at push time.
- Mid-fold reset: the partial accumulation is discarded and no result is emitted.

Test Plan (WIDTH=8, DEPTH=2, CNT_W=8):
1. Bitwise ops, A=0xF0, B=0x3C, out_ready=1:
   - AND -> 0x30, OR -> 0xFC, NAND -> 0xCF, NOR -> 0x03, XOR -> 0xCC, XNOR -> 0x33, PASS_A -> 0xF0, PASS_B -> 0x3C.
   - Each result appears one cycle after accept, with out_beats=1.
   - A=0xFF, B=0xFF, XOR -> 0x00 with out_zero=1.
2. Fold XOR, three beats:
   - Beats: (A=0x01, B=0x02, last=0), (B=0x04, in_op=0 ignored, last=0), (B=0x08, last=1).
   - Single push 0x0F with out_beats=3. Mid-fold beats produce no out_valid.
3. Single-beat fold:
   - AND with A=0xAA, B=0x0F, last=1 -> 0x0A, out_beats=1, FSM stays IDLE.
4. Backpressure:
   - out_ready=0 with 3 bitwise XOR beats (0x01^0x00, 0x02^0x00, 0x03^0x00).
   - in_ready falls after 2 accepts and the third is held.
   - Raise out_ready: outputs 0x01, 0x02, 0x03 in order, and in_ready rises one cycle after the first pop.
5. Full FIFO with simultaneous pop and valid input:
   - Only the pop occurs that cycle; the input is accepted next cycle. No loss or duplication over 20 random beats checked against a reference model.
6. Reset mid-fold:
   - Two non-last OR beats, then rst_n=0 for 1 cycle, then a bitwise AND A=0x0F, B=0xFF.
   - Only 0x0F is output, with out_beats=1 and FSM in IDLE.
